bram_byte_fifo: RTL



---
 rtl/bram_fifo_pkg.sv | 11 +
 rtl/fifo_out_skid.sv | 52 +++++
 rtl/bram_byte_fifo.sv | 101 ++++++++++
 3 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared sizing and BlockRAM configuration constants for the BlockRAM-backed byte FIFO.
package bram_fifo_pkg;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned PTR_W   = 10;
  localparam int unsigned LEVEL_W = 11;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BRAM_W  = 32;
  localparam int unsigned OCC_W   = 2;
  // {C5..C0}: 8-bit write, 8-bit read, dynamic write enable, no output register
  localparam logic [5:0] BRAM_CFG = 6'b000101;
endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry output buffer that catches BlockRAM read data and presents the head byte.
module fifo_out_skid
  import bram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occupancy
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d, occ_mid;
  logic              pop;

  assign out_valid = (occ_q != '0);
  assign out_data  = head_q;
  assign occupancy = occ_q;
  assign pop       = out_valid && out_ready;

  // Pop shifts the tail forward first, then a captured byte lands in the first free slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_mid = occ_q;
    if (pop) begin
      head_d  = tail_q;
      occ_mid = occ_q - OCC_W'(1);
    end
    occ_d = occ_mid;
    if (in_valid) begin
      if (occ_mid == '0) head_d = in_data;
      else               tail_d = in_data;
      occ_d = occ_mid + OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/bram_byte_fifo.sv
// 1 KB byte FIFO stored in an external BlockRAM; address MSBs and the write
// enable travel on spare bram_wr_data bits, reads land in a 2-entry output buffer.
module bram_byte_fifo
  import bram_fifo_pkg::*;
#(
  parameter int unsigned READ_ADDRESS_MSB_FROM_DATALSB  = 24,
  parameter int unsigned WRITE_ADDRESS_MSB_FROM_DATALSB = 16,
  parameter int unsigned WRITE_ENABLE_FROM_DATA         = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [LEVEL_W-1:0] level,
  output logic [7:0]         bram_wr_addr,
  output logic [7:0]         bram_rd_addr,
  output logic [BRAM_W-1:0]  bram_wr_data,
  input  logic [BRAM_W-1:0]  bram_rd_data,
  output logic [5:0]         bram_cfg
);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               rd_inflight_q, rd_inflight_d;
  logic [PTR_W-1:0]   fill;
  logic [2:0]         pending;
  logic               push, pop, rd_issue;
  logic               skid_valid;
  logic [OCC_W-1:0]   skid_occ;
  logic               rd_data_unused;

  assign bram_cfg       = BRAM_CFG;
  assign rd_data_unused = ^bram_rd_data[BRAM_W-1:DATA_W];

  assign s_ready = !rst && (level_q != LEVEL_W'(DEPTH));
  assign push    = s_valid && s_ready;
  assign m_valid = skid_valid && !rst;
  assign pop     = m_valid && m_ready;
  assign level   = rst ? '0 : level_q;

  // Buffer slots already claimed once this cycle's pop frees one; at most two outstanding.
  assign fill     = wr_ptr_q - rd_ptr_q;
  assign pending  = 3'(rd_inflight_q) + 3'(skid_occ) - 3'(pop);
  assign rd_issue = !rst && (fill != '0) && (pending < 3'd2);

  assign bram_wr_addr = wr_ptr_q[7:0];
  assign bram_rd_addr = rd_ptr_q[7:0];

  always_comb begin
    bram_wr_data = '0;
    if (push) begin
      bram_wr_data[DATA_W-1:0]                          = s_data;
      bram_wr_data[WRITE_ADDRESS_MSB_FROM_DATALSB +: 2] = wr_ptr_q[PTR_W-1 -: 2];
      bram_wr_data[WRITE_ENABLE_FROM_DATA]              = 1'b1;
    end
    if (rd_issue) begin
      bram_wr_data[READ_ADDRESS_MSB_FROM_DATALSB +: 2] = rd_ptr_q[PTR_W-1 -: 2];
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(rd_issue);
    rd_inflight_d = rd_issue;
    level_d       = level_q;
    if (push && !pop)      level_d = level_q + LEVEL_W'(1);
    else if (pop && !push) level_d = level_q - LEVEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // Read data is only taken in the cycle after an issue, so returns across reset are dropped.
  fifo_out_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_inflight_q),
    .in_data   (bram_rd_data[DATA_W-1:0]),
    .out_valid (skid_valid),
    .out_data  (m_data),
    .out_ready (m_ready && !rst),
    .occupancy (skid_occ)
  );

endmodule
